ex_stage: RTL and testbench



---
 rtl/ex_stage_if.sv | 51 +++++
 rtl/ex_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the ID->EX input bus and stall vector together with
// every EX-stage output (EX->MEM bus, data SRAM request, forwarding, stall
// request). The master modport is the execute stage. The slave modport is the
// surrounding pipeline.
interface ex_stage_if #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76
);
    logic [5:0]              stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;
    logic                    ex_wreg_o;
    logic [4:0]              ex_waddr_o;
    logic [31:0]             ex_wdata_o;
    logic                    ex_is_load_o;
    logic                    stallreq_for_ex;

    modport master (
        input  stall,
        input  id_to_ex_bus,
        output ex_to_mem_bus,
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        output ex_wreg_o,
        output ex_waddr_o,
        output ex_wdata_o,
        output ex_is_load_o,
        output stallreq_for_ex
    );

    modport slave (
        output stall,
        output id_to_ex_bus,
        input  ex_to_mem_bus,
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  ex_wreg_o,
        input  ex_waddr_o,
        input  ex_wdata_o,
        input  ex_is_load_o,
        input  stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
// It registers the ID->EX bus and computes the 12-operation ALU result.
// It issues the data-SRAM request and drives EX forwarding back to ID.
// It also owns the HI/LO registers.
// Define EX_DIV_EN to build the iterative restoring divider. The divider
// takes 32 steps and holds the pipeline while it is busy. Without EX_DIV_EN,
// div/divu leave HI/LO unchanged and stallreq_for_ex is 0.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.master io
);

    logic [ID_TO_EX_WD-1:0]  ex_bus_r;

    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_res;
    logic [31:0] ex_result;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem;

    logic        is_special;
    logic        is_mfhi;
    logic        is_mflo;
    logic        is_mthi;
    logic        is_mtlo;

    logic [31:0] hi;
    logic [31:0] lo;

    logic        unused_bits;

    // Pipeline register: reset, bubble when ID holds but EX advances, load when ID advances, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_bus_r <= '0;
        end else if (io.stall[2] && !io.stall[3]) begin
            ex_bus_r <= '0;
        end else if (!io.stall[2]) begin
            ex_bus_r <= io.id_to_ex_bus;
        end
    end

    assign pc           = ex_bus_r[158:127];
    assign inst         = ex_bus_r[126:95];
    assign alu_op       = ex_bus_r[94:83];
    assign sel_alu_src1 = ex_bus_r[82:80];
    assign sel_alu_src2 = ex_bus_r[79:76];
    assign data_ram_en  = ex_bus_r[75];
    assign data_ram_wen = ex_bus_r[74:71];
    assign rf_we        = ex_bus_r[70];
    assign rf_waddr     = ex_bus_r[69:65];
    assign sel_rf_res   = ex_bus_r[64];
    assign rdata1       = ex_bus_r[63:32];
    assign rdata2       = ex_bus_r[31:0];

    // Operand select: one-hot selects are OR-combined; no select bit gives 0.
    always_comb begin
        src1 = '0;
        if (sel_alu_src1[0]) src1 = src1 | rdata1;
        if (sel_alu_src1[1]) src1 = src1 | pc;
        if (sel_alu_src1[2]) src1 = src1 | {27'd0, inst[10:6]};

        src2 = '0;
        if (sel_alu_src2[0]) src2 = src2 | rdata2;
        if (sel_alu_src2[1]) src2 = src2 | {{16{inst[15]}}, inst[15:0]};
        if (sel_alu_src2[2]) src2 = src2 | 32'd8;
        if (sel_alu_src2[3]) src2 = src2 | {16'd0, inst[15:0]};
    end

    // ALU: each op bit gates its own result, so no op bit gives 0.
    // Shifts take src2 as the data and src1[4:0] as the amount.
    always_comb begin
        alu_res = '0;
        if (alu_op[11]) alu_res = alu_res | (src1 + src2);
        if (alu_op[10]) alu_res = alu_res | (src1 - src2);
        if (alu_op[9])  alu_res = alu_res | {31'd0, $signed(src1) < $signed(src2)};
        if (alu_op[8])  alu_res = alu_res | {31'd0, src1 < src2};
        if (alu_op[7])  alu_res = alu_res | (src1 & src2);
        if (alu_op[6])  alu_res = alu_res | ~(src1 | src2);
        if (alu_op[5])  alu_res = alu_res | (src1 | src2);
        if (alu_op[4])  alu_res = alu_res | (src1 ^ src2);
        if (alu_op[3])  alu_res = alu_res | (src2 << src1[4:0]);
        if (alu_op[2])  alu_res = alu_res | (src2 >> src1[4:0]);
        if (alu_op[1])  alu_res = alu_res | 32'($signed(src2) >>> src1[4:0]);
        if (alu_op[0])  alu_res = alu_res | {src2[15:0], 16'd0};
    end

    assign is_special = (inst[31:26] == 6'd0);
    assign is_mfhi    = is_special && (inst[5:0] == 6'h10);
    assign is_mthi    = is_special && (inst[5:0] == 6'h11);
    assign is_mflo    = is_special && (inst[5:0] == 6'h12);
    assign is_mtlo    = is_special && (inst[5:0] == 6'h13);

    // Result select: mfhi/mflo read HI/LO; all other instructions use the ALU.
    always_comb begin
        if (is_mfhi) begin
            ex_result = hi;
        end else if (is_mflo) begin
            ex_result = lo;
        end else begin
            ex_result = alu_res;
        end
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    div_state_t  div_state;
    logic [5:0]  div_cnt;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] div_dsr;
    logic        div_neg_q;
    logic        div_neg_r;
    logic        div_wr;

    logic        is_div;
    logic        is_divu;
    logic        div_in_ex;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [32:0] trial;
    logic        trial_ge;
    logic [31:0] rem_next;
    logic [31:0] lo_final;
    logic [31:0] hi_final;

    assign is_div    = is_special && (inst[5:0] == 6'h1A);
    assign is_divu   = is_special && (inst[5:0] == 6'h1B);
    assign div_in_ex = is_div || is_divu;

    assign dividend_abs = (is_div && rdata1[31]) ? (32'd0 - rdata1) : rdata1;
    assign divisor_abs  = (is_div && rdata2[31]) ? (32'd0 - rdata2) : rdata2;

    // The step shifts the next dividend bit into the partial remainder.
    // A zero divisor always subtracts, so the quotient becomes all ones and the
    // remainder ends equal to the dividend magnitude without any special case.
    assign trial    = {div_rem, div_quo[31]};
    assign trial_ge = (trial >= {1'b0, div_dsr});
    assign rem_next = trial_ge ? (trial[31:0] - div_dsr) : trial[31:0];

    assign lo_final = div_neg_q ? (32'd0 - div_quo) : div_quo;
    assign hi_final = div_neg_r ? (32'd0 - div_rem) : div_rem;

    // Divider sequencer: latch magnitudes, run 32 restoring steps, then pulse one HI/LO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
            div_quo   <= '0;
            div_rem   <= '0;
            div_dsr   <= '0;
            div_neg_q <= 1'b0;
            div_neg_r <= 1'b0;
            div_wr    <= 1'b0;
        end else begin
            div_wr <= 1'b0;
            case (div_state)
                DIV_IDLE: begin
                    if (div_in_ex) begin
                        div_state <= DIV_BUSY;
                        div_cnt   <= '0;
                        div_quo   <= dividend_abs;
                        div_rem   <= '0;
                        div_dsr   <= divisor_abs;
                        div_neg_q <= is_div && (rdata1[31] ^ rdata2[31]);
                        div_neg_r <= is_div && rdata1[31];
                    end
                end
                DIV_BUSY: begin
                    div_quo <= {div_quo[30:0], trial_ge};
                    div_rem <= rem_next;
                    div_cnt <= div_cnt + 6'd1;
                    if (div_cnt == 6'd31) begin
                        div_state <= DIV_DONE;
                        div_wr    <= 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (!io.stall[3]) begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: begin
                    div_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign io.stallreq_for_ex = div_in_ex && (div_state != DIV_DONE);
`else
    assign io.stallreq_for_ex = 1'b0;
`endif

    // HI/LO: mthi/mtlo commit on the edge where EX advances; the divider commits once on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (!io.stall[3] && is_mthi) hi <= rdata1;
            if (!io.stall[3] && is_mtlo) lo <= rdata1;
`ifdef EX_DIV_EN
            if (div_wr) begin
                hi <= hi_final;
                lo <= lo_final;
            end
`endif
        end
    end

    assign ex_to_mem = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};

    assign io.ex_to_mem_bus   = ex_to_mem;
    assign io.data_sram_en    = data_ram_en;
    assign io.data_sram_wen   = data_ram_wen;
    assign io.data_sram_addr  = alu_res;
    assign io.data_sram_wdata = rdata2;
    assign io.ex_wreg_o       = rf_we;
    assign io.ex_waddr_o      = rf_waddr;
    assign io.ex_wdata_o      = ex_result;
    assign io.ex_is_load_o    = sel_rf_res;

    assign unused_bits = ^{io.stall[5:4], io.stall[1:0], inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage.
// Stimulus pushes the expected value for a given cycle into a queue. A monitor
// on the falling edge pops every entry due that cycle and compares it with the
// DUT outputs. Define EX_DIV_EN here as for the RTL to select divider expectations.
module tb_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if #(.ID_TO_EX_WD(159), .EX_TO_MEM_WD(76)) dif ();

    ex_stage #(.ID_TO_EX_WD(159), .EX_TO_MEM_WD(76)) dut (
        .clk (clk),
        .rst (rst),
        .io  (dif)
    );

    typedef enum int {
        S_RES, S_WREG, S_WADDR, S_BUS, S_SEN, S_SWEN, S_SADDR, S_SWDATA, S_LOAD, S_STALLREQ
    } sel_t;

    typedef struct {
        string       name;
        int unsigned cyc;
        sel_t        sel;
        logic [75:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [75:0] actual(input sel_t s);
        case (s)
            S_RES:      return {44'd0, dif.ex_wdata_o};
            S_WREG:     return {75'd0, dif.ex_wreg_o};
            S_WADDR:    return {71'd0, dif.ex_waddr_o};
            S_BUS:      return dif.ex_to_mem_bus;
            S_SEN:      return {75'd0, dif.data_sram_en};
            S_SWEN:     return {72'd0, dif.data_sram_wen};
            S_SADDR:    return {44'd0, dif.data_sram_addr};
            S_SWDATA:   return {44'd0, dif.data_sram_wdata};
            S_LOAD:     return {75'd0, dif.ex_is_load_o};
            S_STALLREQ: return {75'd0, dif.stallreq_for_ex};
            default:    return '0;
        endcase
    endfunction

    // Monitor: compare every scoreboard entry due in the current cycle.
    always @(negedge clk) begin
        int i;
        logic [75:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                act = actual(sb[i].sel);
                checks++;
                if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %h, want %h", sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: due at cycle %0d, never compared", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(input string name, input sel_t sel, input logic [75:0] val, input int unsigned at);
        exp_t e;
        e.name = name;
        e.cyc  = at;
        e.sel  = sel;
        e.exp  = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [158:0] mk(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
        input logic [2:0] s1, input logic [3:0] s2, input logic en, input logic [3:0] wen,
        input logic we, input logic [4:0] wa, input logic selres,
        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, en, wen, we, wa, selres, r1, r2};
    endfunction

    function automatic logic [75:0] mkout(
        input logic [31:0] pc, input logic en, input logic [3:0] wen, input logic selres,
        input logic we, input logic [4:0] wa, input logic [31:0] res);
        return {pc, en, wen, selres, we, wa, res};
    endfunction

    localparam logic [31:0] PC0 = 32'hBFC0_0100;

    // Issue one register-writing ALU instruction and expect its result next cycle.
    task automatic alu_case(input string name, input logic [31:0] inst, input logic [11:0] op,
                            input logic [2:0] s1, input logic [3:0] s2,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [4:0] wa, input logic [31:0] exp);
        dif.stall        = 6'd0;
        dif.id_to_ex_bus = mk(PC0, inst, op, s1, s2, 1'b0, 4'd0, 1'b1, wa, 1'b0, r1, r2);
        expect_at({name, ".res"},   S_RES,   {44'd0, exp}, cyc + 1);
        expect_at({name, ".wreg"},  S_WREG,  76'd1,        cyc + 1);
        expect_at({name, ".waddr"}, S_WADDR, {71'd0, wa},  cyc + 1);
        expect_at({name, ".bus"},   S_BUS,   mkout(PC0, 1'b0, 4'd0, 1'b0, 1'b1, wa, exp), cyc + 1);
        tick();
    endtask

    // Special-opcode instruction (mthi/mtlo/mfhi/mflo/div/divu) by function code.
    function automatic logic [158:0] spec_ins(input logic [5:0] func, input logic we,
                                             input logic [31:0] r1, input logic [31:0] r2);
        return mk(PC0, {26'd0, func}, 12'd0, 3'b001, 4'b0001, 1'b0, 4'd0, we, 5'd2, 1'b0, r1, r2);
    endfunction

    task automatic read_hilo(input string name, input logic [5:0] func, input logic [31:0] exp);
        dif.stall        = 6'd0;
        dif.id_to_ex_bus = spec_ins(func, 1'b1, 32'd0, 32'd0);
        expect_at(name, S_RES, {44'd0, exp}, cyc + 1);
        tick();
    endtask

`ifdef EX_DIV_EN
    task automatic do_div(input string name, input logic [5:0] func, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lo_exp, input logic [31:0] hi_exp);
        int unsigned t;
        t = cyc + 1;
        dif.stall        = 6'd0;
        dif.id_to_ex_bus = spec_ins(func, 1'b0, a, b);
        for (int k = 0; k < 33; k++) expect_at({name, ".stallreq_hi"}, S_STALLREQ, 76'd1, t + k);
        expect_at({name, ".stallreq_lo"}, S_STALLREQ, 76'd0, t + 33);
        tick();
        for (int k = 0; k < 33; k++) begin
            dif.stall        = 6'b001111;
            dif.id_to_ex_bus = spec_ins(6'h12, 1'b1, 32'd0, 32'd0);
            tick();
        end
        read_hilo({name, ".mflo"}, 6'h12, lo_exp);
        read_hilo({name, ".mfhi"}, 6'h10, hi_exp);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned c0;
        rst              = 1'b1;
        dif.stall        = 6'd0;
        dif.id_to_ex_bus = '0;
        tick();
        expect_at("reset.bus",      S_BUS,      76'd0, cyc);
        expect_at("reset.wreg",     S_WREG,     76'd0, cyc);
        expect_at("reset.sram_en",  S_SEN,      76'd0, cyc);
        expect_at("reset.stallreq", S_STALLREQ, 76'd0, cyc);
        tick();
        rst = 1'b0;

        alu_case("addiu", 32'h2508FFFF, 12'h800, 3'b001, 4'b0010, 32'd5,         32'd0,         5'd8,  32'd4);
        alu_case("ori",   32'h35088000, 12'h020, 3'b001, 4'b1000, 32'h0001_0000, 32'd0,         5'd9,  32'h0001_8000);
        alu_case("lui",   32'h3C081234, 12'h001, 3'b000, 4'b0010, 32'd0,         32'd0,         5'd10, 32'h1234_0000);
        alu_case("sra",   32'h00094103, 12'h002, 3'b100, 4'b0001, 32'd0,         32'h8000_0000, 5'd11, 32'hF800_0000);
        alu_case("sub",   32'h00000023, 12'h400, 3'b001, 4'b0001, 32'd3,         32'd5,         5'd12, 32'hFFFF_FFFE);
        alu_case("slt",   32'h0000002A, 12'h200, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1,         5'd13, 32'd1);
        alu_case("sltu",  32'h0000002B, 12'h100, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1,         5'd14, 32'd0);
        alu_case("and",   32'h00000024, 12'h080, 3'b001, 4'b0001, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd15, 32'h0F00_0F00);
        alu_case("nor",   32'h00000027, 12'h040, 3'b001, 4'b0001, 32'h0F0F_0000, 32'h0000_00FF, 5'd16, 32'hF0F0_FF00);
        alu_case("xor",   32'h00000026, 12'h010, 3'b001, 4'b0001, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd17, 32'hF0F0_0F0F);
        alu_case("sll",   32'h00000200, 12'h008, 3'b100, 4'b0001, 32'd0,         32'h0000_00AB, 5'd18, 32'h0000_AB00);
        alu_case("srl",   32'h00000102, 12'h004, 3'b100, 4'b0001, 32'd0,         32'h8000_0000, 5'd19, 32'h0800_0000);
        alu_case("jal",   32'h0C000000, 12'h800, 3'b010, 4'b0100, 32'd0,         32'd0,         5'd31, 32'hBFC0_0108);
        alu_case("noop",  32'h00000025, 12'h000, 3'b001, 4'b0001, 32'd1,         32'd2,         5'd20, 32'd0);

        // Store word: address from the ALU, data from rdata2.
        dif.id_to_ex_bus = mk(PC0, 32'hAC090008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
                              32'h0000_1000, 32'hDEAD_BEEF);
        expect_at("sw.addr",  S_SADDR,  76'h1008,        cyc + 1);
        expect_at("sw.wdata", S_SWDATA, 76'hDEAD_BEEF,   cyc + 1);
        expect_at("sw.en",    S_SEN,    76'd1,           cyc + 1);
        expect_at("sw.wen",   S_SWEN,   76'hF,           cyc + 1);
        expect_at("sw.wreg",  S_WREG,   76'd0,           cyc + 1);
        tick();

        // Load word: flagged as a load for load-use detection.
        dif.id_to_ex_bus = mk(PC0, 32'h8C090008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd9, 1'b1,
                              32'h0000_2000, 32'd0);
        expect_at("lw.is_load", S_LOAD,  76'd1,    cyc + 1);
        expect_at("lw.addr",    S_SADDR, 76'h2008, cyc + 1);
        expect_at("lw.wen",     S_SWEN,  76'd0,    cyc + 1);
        tick();

        // Hold with ID and EX both stopped, then a bubble with only ID stopped.
        alu_case("hold_src", 32'h2508FFFF, 12'h800, 3'b001, 4'b0010, 32'd5, 32'd0, 5'd3, 32'd4);
        dif.stall        = 6'b001100;
        dif.id_to_ex_bus = mk(PC0, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'd0, 1'b1, 5'd7, 1'b0, 32'd9, 32'd9);
        expect_at("hold.res", S_RES, 76'd4, cyc + 1);
        tick();
        dif.stall = 6'b000100;
        expect_at("bubble.bus",  S_BUS,  76'd0, cyc + 1);
        expect_at("bubble.wreg", S_WREG, 76'd0, cyc + 1);
        tick();
        dif.stall = 6'd0;

        // Reset with a valid store in EX clears every output.
        dif.id_to_ex_bus = mk(PC0, 32'hAC090008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b1, 5'd4, 1'b0,
                              32'h0000_1000, 32'hDEAD_BEEF);
        tick();
        rst = 1'b1;
        expect_at("rst.bus",      S_BUS,    76'd0, cyc + 1);
        expect_at("rst.sram_en",  S_SEN,    76'd0, cyc + 1);
        expect_at("rst.sram_wen", S_SWEN,   76'd0, cyc + 1);
        expect_at("rst.addr",     S_SADDR,  76'd0, cyc + 1);
        expect_at("rst.wdata",    S_SWDATA, 76'd0, cyc + 1);
        expect_at("rst.wreg",     S_WREG,   76'd0, cyc + 1);
        expect_at("rst.waddr",    S_WADDR,  76'd0, cyc + 1);
        tick();
        rst              = 1'b0;
        dif.id_to_ex_bus = '0;
        tick();

        // HI/LO after reset, then each move followed directly by its read.
        read_hilo("hi_after_rst", 6'h10, 32'd0);
        dif.id_to_ex_bus = spec_ins(6'h11, 1'b0, 32'h11, 32'd0);
        tick();
        read_hilo("mfhi_after_mthi", 6'h10, 32'h11);
        dif.id_to_ex_bus = spec_ins(6'h13, 1'b0, 32'h22, 32'd0);
        tick();
        read_hilo("mflo_after_mtlo", 6'h12, 32'h22);

`ifdef EX_DIV_EN
        do_div("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("divu_7_0", 6'h1B, 32'd7,         32'd0, 32'hFFFF_FFFF, 32'd7);

        // Reset in the middle of a division aborts it and clears HI/LO.
        dif.id_to_ex_bus = spec_ins(6'h1A, 1'b0, 32'd100, 32'd3);
        tick();
        for (int k = 0; k < 5; k++) begin
            dif.stall = 6'b001111;
            tick();
        end
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        dif.stall = 6'd0;
        expect_at("rst_div.stallreq", S_STALLREQ, 76'd0, cyc);
        read_hilo("rst_div.mfhi", 6'h10, 32'd0);
        read_hilo("rst_div.mflo", 6'h12, 32'd0);
`else
        c0               = cyc + 1;
        dif.id_to_ex_bus = spec_ins(6'h1A, 1'b0, 32'd8, 32'd2);
        expect_at("nodiv.stallreq", S_STALLREQ, 76'd0, c0);
        tick();
        read_hilo("nodiv.mflo", 6'h12, 32'h22);
        read_hilo("nodiv.mfhi", 6'h10, 32'h11);
`endif

        dif.id_to_ex_bus = '0;
        tick();
        tick();
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: due at cycle %0d, never compared", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
